// File: rtl/image_ctrl_pkg.sv
// image_ctrl_pkg: shared types, constants and helpers for the ImageController refill scheduler.
package image_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_IRQ_PEND,
        S_XFER,
        S_FRAME_END
    } sched_state_e;

    localparam int MAX_BURST_DEF     = 256;
    localparam int MIN_BURST_DEF     = 16;
    localparam int STATUS_REQLEN_LSB = 64;
    localparam int STATUS_FCNT_LSB   = 32;

    localparam logic [31:0] ADDR_STATUS = 32'hA001_0000;
    localparam logic [31:0] ADDR_DATA   = 32'hA001_0030;
    localparam logic [31:0] ADDR_DONE   = 32'hA001_0040;

    function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/image_refill_scheduler.sv
// image_refill_scheduler: grants one PS write burst at a time into the pixel FIFO via irq,
// then closes it out on the host's done write with length checking and frame auto-restart.
module image_refill_scheduler
    import image_ctrl_pkg::*;
#(
    parameter int FIFO_AW   = 10,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int MIN_BURST = MIN_BURST_DEF
) (
    input  logic               s_axi_aclk,
    input  logic               reset,
    input  logic               start,
    input  logic               auto_restart,
    input  logic [31:0]        frame_beats,
    input  logic [FIFO_AW:0]   fifo_free,
    input  logic               beat_valid,
    input  logic               status_rd,
    input  logic               done_wr,
    output logic               irq,
    output logic [8:0]         req_len,
    output logic [127:0]       status_word,
    output logic               busy,
    output logic               frame_done,
    output logic               err_len,
    output logic               err_stray
);

    sched_state_e state_q, state_d;
    logic [31:0]  remaining_q, remaining_d;
    logic [31:0]  frame_count_q, frame_count_d;
    logic [8:0]   beat_cnt_q, beat_cnt_d;
    logic [8:0]   req_len_q, req_len_d;
    logic         irq_q, irq_d;
    logic         busy_q, busy_d;
    logic         frame_done_q, frame_done_d;
    logic         err_len_q, err_len_d;
    logic         err_stray_q, err_stray_d;
    logic [127:0] status_word_q, status_word_d;

    logic [31:0] want;
    logic [9:0]  cnt_sum;
    logic [8:0]  cnt_eff;
    logic [31:0] rem_after;
    logic        grant_ok;

    always_comb begin
        want      = min32(remaining_q, 32'(MAX_BURST));
        grant_ok  = (32'(fifo_free) >= want) && ((want >= 32'(MIN_BURST)) || (want == remaining_q));
        cnt_sum   = {1'b0, beat_cnt_q} + 10'(beat_valid);
        cnt_eff   = (cnt_sum > 10'(MAX_BURST)) ? 9'(MAX_BURST) : cnt_sum[8:0];
        // A short or long burst only retires what actually arrived, never below zero.
        rem_after = (cnt_eff == req_len_q) ? remaining_q - 32'(req_len_q)
                                           : remaining_q - min32(32'(cnt_eff), remaining_q);
        state_d       = state_q;
        remaining_d   = remaining_q;
        frame_count_d = frame_count_q;
        beat_cnt_d    = beat_cnt_q;
        req_len_d     = req_len_q;
        irq_d         = irq_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        err_len_d     = err_len_q;
        err_stray_d   = err_stray_q | (beat_valid && state_q != S_XFER);
        case (state_q)
            S_IDLE: if (start && frame_beats != 32'd0) begin
                remaining_d = frame_beats;
                busy_d      = 1'b1;
                state_d     = S_WAIT_SPACE;
            end
            S_WAIT_SPACE: if (grant_ok) begin
                req_len_d = want[8:0];
                irq_d     = 1'b1;
                state_d   = S_IRQ_PEND;
            end
            S_IRQ_PEND: if (status_rd) begin
                irq_d   = 1'b0;
                state_d = S_XFER;
            end
            S_XFER: begin
                beat_cnt_d = done_wr ? 9'd0 : cnt_eff;
                if (done_wr) begin
                    err_len_d   = err_len_q | (cnt_eff != req_len_q);
                    remaining_d = rem_after;
                    state_d     = (rem_after == 32'd0) ? S_FRAME_END : S_WAIT_SPACE;
                end
            end
            S_FRAME_END: begin
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 32'd1;
                if (auto_restart && frame_beats != 32'd0) begin
                    remaining_d = frame_beats;
                    state_d     = S_WAIT_SPACE;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        status_word_d = '0;
        status_word_d[STATUS_REQLEN_LSB +: 9] = req_len_d;
        status_word_d[STATUS_FCNT_LSB +: 32]  = frame_count_d;
        status_word_d[31:0]                   = remaining_d;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            remaining_q   <= '0;
            frame_count_q <= '0;
            beat_cnt_q    <= '0;
            req_len_q     <= '0;
            irq_q         <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_len_q     <= 1'b0;
            err_stray_q   <= 1'b0;
            status_word_q <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            frame_count_q <= frame_count_d;
            beat_cnt_q    <= beat_cnt_d;
            req_len_q     <= req_len_d;
            irq_q         <= irq_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            err_len_q     <= err_len_d;
            err_stray_q   <= err_stray_d;
            status_word_q <= status_word_d;
        end
    end

    assign irq         = irq_q;
    assign req_len     = req_len_q;
    assign status_word = status_word_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err_len     = err_len_q;
    assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_image_refill_scheduler.sv
// tb_image_refill_scheduler: directed bench for the refill scheduler with hand-computed expectations.
module tb_image_refill_scheduler;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         auto_restart = 1'b0;
    logic [31:0]  frame_beats = '0;
    logic [10:0]  fifo_free = '0;
    logic         beat_valid = 1'b0;
    logic         status_rd = 1'b0;
    logic         done_wr = 1'b0;
    logic         irq;
    logic [8:0]   req_len;
    logic [127:0] status_word;
    logic         busy;
    logic         frame_done;
    logic         err_len;
    logic         err_stray;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int fd_base;

    image_refill_scheduler #(.FIFO_AW(10), .MAX_BURST(256), .MIN_BURST(16)) dut (
        .s_axi_aclk  (clk),
        .reset       (reset),
        .start       (start),
        .auto_restart(auto_restart),
        .frame_beats (frame_beats),
        .fifo_free   (fifo_free),
        .beat_valid  (beat_valid),
        .status_rd   (status_rd),
        .done_wr     (done_wr),
        .irq         (irq),
        .req_len     (req_len),
        .status_word (status_word),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_len     (err_len),
        .err_stray   (err_stray)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_cnt++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (!irq && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_irq"}, 128'(irq), 128'(1));
    endtask

    task automatic pulse_start(input logic [31:0] beats);
        frame_beats = beats;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic grant(input int exp_len, input int nbeats, input bit coincide, input string tag);
        wait_irq(tag);
        chk({tag, "_len"}, 128'(req_len), 128'(exp_len));
        status_rd = 1'b1;
        @(negedge clk);
        status_rd = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            beat_valid = 1'b1;
            if (coincide && i == nbeats - 1) done_wr = 1'b1;
            @(negedge clk);
        end
        beat_valid = 1'b0;
        if (!coincide) begin
            done_wr = 1'b1;
            @(negedge clk);
        end
        done_wr = 1'b0;
    endtask

    task automatic run600(input string tag);
        fifo_free = 11'd1024;
        auto_restart = 1'b0;
        fd_base = fd_cnt;
        pulse_start(32'd600);
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        chk({tag, "_rem0"}, 128'(status_word[31:0]), 128'(600));
        grant(256, 256, 1'b0, {tag, "_g1"});
        chk({tag, "_rem1"}, 128'(status_word[31:0]), 128'(344));
        grant(256, 256, 1'b0, {tag, "_g2"});
        chk({tag, "_rem2"}, 128'(status_word[31:0]), 128'(88));
        grant(88, 88, 1'b0, {tag, "_g3"});
        repeat (2) @(negedge clk);
        chk({tag, "_fdone"}, 128'(fd_cnt - fd_base), 128'(1));
        chk({tag, "_fcnt"}, 128'(status_word[63:32]), 128'(1));
        chk({tag, "_idle"}, 128'(busy), 128'(0));
        chk({tag, "_errlen"}, 128'(err_len), 128'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_irq", 128'(irq), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_status", status_word, 128'(0));
        chk("rst_errs", 128'({err_len, err_stray}), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        fifo_free = 11'd1024;
        pulse_start(32'd0);
        chk("zero_start", 128'(busy), 128'(0));

        run600("t1");

        fifo_free = 11'd100;
        fd_base = fd_cnt;
        pulse_start(32'd256);
        beat_valid = 1'b1;
        @(negedge clk);
        beat_valid = 1'b0;
        chk("stray_flag", 128'(err_stray), 128'(1));
        chk("stray_rem", 128'(status_word[31:0]), 128'(256));
        chk("stray_noirq", 128'(irq), 128'(0));
        fifo_free = 11'd1024;
        grant(256, 256, 1'b1, "coin");
        repeat (2) @(negedge clk);
        chk("coin_errlen", 128'(err_len), 128'(0));
        chk("coin_fdone", 128'(fd_cnt - fd_base), 128'(1));
        chk("coin_fcnt", 128'(status_word[63:32]), 128'(2));

        pulse_start(32'd600);
        wait_irq("rst_mid");
        status_rd = 1'b1;
        @(negedge clk);
        status_rd = 1'b0;
        repeat (50) begin
            beat_valid = 1'b1;
            @(negedge clk);
        end
        beat_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rmid_irq", 128'(irq), 128'(0));
        chk("rmid_busy", 128'(busy), 128'(0));
        chk("rmid_status", status_word, 128'(0));
        chk("rmid_stray", 128'(err_stray), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        run600("t6");

        fifo_free = 11'd100;
        fd_base = fd_cnt;
        pulse_start(32'd300);
        repeat (20) @(negedge clk);
        chk("space_noirq", 128'(irq), 128'(0));
        fifo_free = 11'd256;
        @(negedge clk);
        chk("space_irq", 128'(irq), 128'(1));
        chk("space_len", 128'(req_len), 128'(256));
        chk("space_sw", 128'(status_word[127:64]), 128'(256));
        grant(256, 200, 1'b0, "short");
        chk("short_errlen", 128'(err_len), 128'(1));
        chk("short_rem", 128'(status_word[31:0]), 128'(100));
        grant(100, 100, 1'b0, "tail");
        repeat (2) @(negedge clk);
        chk("tail_rem", 128'(status_word[31:0]), 128'(0));
        chk("tail_fcnt", 128'(status_word[63:32]), 128'(2));
        chk("tail_fdone", 128'(fd_cnt - fd_base), 128'(1));

        fifo_free = 11'd1024;
        auto_restart = 1'b1;
        fd_base = fd_cnt;
        pulse_start(32'd64800);
        for (int i = 0; i < 254; i++)
            grant((i < 253) ? 256 : 32, (i < 253) ? 256 : 32, 1'b1, "ar");
        wait_irq("ar_restart");
        chk("ar_fdone", 128'(fd_cnt - fd_base), 128'(1));
        chk("ar_len", 128'(req_len), 128'(256));
        chk("ar_fcnt", 128'(status_word[63:32]), 128'(3));
        chk("ar_rem", 128'(status_word[31:0]), 128'(64800));
        chk("ar_busy", 128'(busy), 128'(1));

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fd_base = fd_cnt;
        pulse_start(32'd16);
        wait_irq("wrap");
        force dut.frame_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.frame_count_q;
        chk("wrap_pre", 128'(status_word[63:32]), 128'(32'hFFFF_FFFF));
        grant(16, 16, 1'b1, "wrap_g");
        wait_irq("wrap_restart");
        chk("wrap_fcnt", 128'(status_word[63:32]), 128'(0));
        chk("wrap_fdone", 128'(fd_cnt - fd_base), 128'(1));
        chk("wrap_len", 128'(req_len), 128'(16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
